// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding, BCD digit
// limits and the preset sanitiser used on load.
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'd0,
        TMR_RUN   = 2'd1,
        TMR_PAUSE = 2'd2,
        TMR_DONE  = 2'd3
    } tmr_state_t;

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] digit,
        input logic [DIGIT_W-1:0] max
    );
        return (digit > max) ? max : digit;
    endfunction

    // Out-of-range digits saturate instead of wrapping, so a bad preset
    // still produces a legal, countable MM:SS value.
    function automatic logic [4*DIGIT_W-1:0] sanitise_preset(
        input logic [4*DIGIT_W-1:0] preset
    );
        logic [4*DIGIT_W-1:0] clean;
        clean[15:12] = clamp_digit(preset[15:12], DIGIT_MAX);
        clean[11:8]  = clamp_digit(preset[11:8],  DIGIT_MAX);
        clean[7:4]   = clamp_digit(preset[7:4],   SEC_TENS_MAX);
        clean[3:0]   = clamp_digit(preset[3:0],   DIGIT_MAX);
        return clean;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One stage of the BCD decrement chain: subtracts the incoming borrow and
// wraps 0 to the digit's maximum, passing the borrow on to the next digit.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic [DIGIT_W-1:0] max,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_next = max;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown game timer held as four BCD digits, stepped by the
// rising edge of the 1 Hz level from the clock divisor.
module countdown_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] INIT_MIN = 8'h03,
    parameter logic [7:0] INIT_SEC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_one_sec,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        time_up
);

    localparam logic [15:0] INIT_VALUE = {INIT_MIN, INIT_SEC};

    tmr_state_t         state_reg;
    logic [DIGIT_W-1:0] digit_reg [4];
    logic [DIGIT_W-1:0] digit_dec [4];
    logic               prev_sec_reg;
    logic               running_reg;
    logic               time_up_reg;

    logic [4:0]         borrow_chain;
    logic               tick;
    logic               count_zero;
    logic               dec_zero;
    logic [15:0]        preset_clean;

    assign tick         = clk_one_sec & ~prev_sec_reg;
    assign preset_clean = sanitise_preset(preset);

    // Digit 0 is sec_ones, digit 3 is min_tens. The chain always subtracts
    // one; the state machine decides whether the result is taken.
    assign borrow_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [DIGIT_W-1:0] MAX = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
            bcd_down_digit u_digit (
                .digit      (digit_reg[gi]),
                .max        (MAX),
                .borrow_in  (borrow_chain[gi]),
                .digit_next (digit_dec[gi]),
                .borrow_out (borrow_chain[gi+1])
            );
        end
    endgenerate

    // A borrow out of min_tens only happens when every digit is zero.
    assign count_zero = borrow_chain[4];
    assign dec_zero   = ({digit_dec[3], digit_dec[2], digit_dec[1], digit_dec[0]} == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= TMR_IDLE;
            prev_sec_reg <= 1'b0;
            running_reg  <= 1'b0;
            time_up_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= INIT_VALUE[i*4 +: 4];
            end
        end else begin
            prev_sec_reg <= clk_one_sec;
            time_up_reg  <= 1'b0;

            case (state_reg)
                TMR_IDLE, TMR_PAUSE: begin
                    if (load) begin
                        for (int i = 0; i < 4; i++) begin
                            digit_reg[i] <= preset_clean[i*4 +: 4];
                        end
                        state_reg   <= TMR_IDLE;
                        running_reg <= 1'b0;
                    end else if (start) begin
                        if (count_zero) begin
                            state_reg   <= TMR_DONE;
                            time_up_reg <= 1'b1;
                        end else begin
                            state_reg   <= TMR_RUN;
                            running_reg <= 1'b1;
                        end
                    end
                end

                TMR_RUN: begin
                    if (pause) begin
                        state_reg   <= TMR_PAUSE;
                        running_reg <= 1'b0;
                    end else if (tick) begin
                        for (int i = 0; i < 4; i++) begin
                            digit_reg[i] <= digit_dec[i];
                        end
                        if (dec_zero) begin
                            state_reg   <= TMR_DONE;
                            running_reg <= 1'b0;
                            time_up_reg <= 1'b1;
                        end
                    end
                end

                TMR_DONE: begin
                    if (load) begin
                        for (int i = 0; i < 4; i++) begin
                            digit_reg[i] <= preset_clean[i*4 +: 4];
                        end
                        state_reg <= TMR_IDLE;
                    end
                end

                default: begin
                    state_reg   <= TMR_IDLE;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    assign min_tens = digit_reg[3];
    assign min_ones = digit_reg[2];
    assign sec_tens = digit_reg[1];
    assign sec_ones = digit_reg[0];
    assign running  = running_reg;
    assign time_up  = time_up_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each step pushes the expected digits,
// running and time_up onto a scoreboard, clocks once and pops/compares.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_one_sec = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, time_up;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_one_sec (clk_one_sec),
        .load        (load),
        .preset      (preset),
        .start       (start),
        .pause       (pause),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .time_up     (time_up)
    );

    task automatic push_exp(input string tag, input logic [15:0] digits,
                            input logic run, input logic tu);
        exp_t e;
        e.tag = tag;
        e.val = {digits, run, tu};
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [17:0] obs;
        test_cnt++;
        obs = {min_tens, min_ones, sec_tens, sec_ones, running, time_up};
        if (sb_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed digits=%h run=%b tu=%b, no expectation queued",
                   obs[17:2], obs[1], obs[0]);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                fail_cnt++;
                $error("FAIL %s: observed digits=%h run=%b tu=%b, expected digits=%h run=%b tu=%b",
                       e.tag, obs[17:2], obs[1], obs[0], e.val[17:2], e.val[1], e.val[0]);
            end
        end
    endtask

    // Drive one cycle of inputs, clock once, then compare 1 time unit later.
    task automatic cyc(input logic ld, input logic [15:0] pre, input logic st,
                       input logic pa, input logic s1, input logic [15:0] exp_digits,
                       input logic exp_run, input logic exp_tu, input string tag);
        load        = ld;
        preset      = pre;
        start       = st;
        pause       = pa;
        clk_one_sec = s1;
        push_exp(tag, exp_digits, exp_run, exp_tu);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset_values", 16'h0300, 1'b0, 1'b0);
        check_pop();
        rst_n = 1'b1;

        // 1: tick in IDLE does nothing
        cyc(0, 16'h0000, 0, 0, 1, 16'h0300, 0, 0, "idle_tick_ignored");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0300, 0, 0, "idle_tick_low");

        // 2: 01:02 counting down through a minute borrow
        cyc(1, 16'h0102, 0, 0, 0, 16'h0102, 0, 0, "load_0102");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0102, 1, 0, "start_run");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0101, 1, 0, "dec_0101");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0101, 1, 0, "held_high_no_dec");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0101, 1, 0, "low_0101");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0100, 1, 0, "dec_0100");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0100, 1, 0, "low_0100");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0059, 1, 0, "dec_0059_borrow");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0, "low_0059");

        // 3: reach 00:00, one-cycle time_up, DONE holds
        cyc(0, 16'h0000, 0, 1, 0, 16'h0059, 0, 0, "pause_0059");
        cyc(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, "pause_load_0002");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, "start_0002");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, "dec_0001");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, "low_0001");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, "reach_zero_time_up");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, "time_up_cleared");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, "done_tick_ignored");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, "done_start_ignored");
        cyc(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, "done_pause_ignored");

        // 4: pause priority and resume
        cyc(1, 16'h0130, 0, 0, 0, 16'h0130, 0, 0, "done_load_0130");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0130, 1, 0, "start_0130");
        cyc(0, 16'h0000, 0, 1, 1, 16'h0130, 0, 0, "pause_beats_tick");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0130, 0, 0, "paused_low1");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0130, 0, 0, "paused_edge1");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0130, 0, 0, "paused_low2");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0130, 0, 0, "paused_edge2");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0130, 0, 0, "paused_low3");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0130, 1, 0, "resume");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0129, 1, 0, "resume_dec_0129");
        cyc(0, 16'h0000, 1, 1, 0, 16'h0129, 0, 0, "start_pause_pauses");
        cyc(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, "pause_load_0000");
        cyc(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, "start_at_zero_done");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, "start_zero_tu_cleared");

        // 5: sanitising, load ignored in RUN, load beats start
        cyc(1, 16'h7A6F, 0, 0, 0, 16'h7959, 0, 0, "load_sanitise_7959");
        cyc(0, 16'h0000, 1, 0, 0, 16'h7959, 1, 0, "start_7959");
        cyc(0, 16'h0000, 0, 0, 1, 16'h7958, 1, 0, "dec_7958");
        cyc(1, 16'h0000, 0, 0, 0, 16'h7958, 1, 0, "run_load_ignored");
        cyc(0, 16'h0000, 0, 0, 1, 16'h7957, 1, 0, "dec_7957");
        cyc(0, 16'h0000, 0, 1, 0, 16'h7957, 0, 0, "pause_7957");
        cyc(1, 16'h1000, 1, 0, 0, 16'h1000, 0, 0, "load_beats_start");
        cyc(0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, "start_1000");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0959, 1, 0, "full_borrow_0959");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0959, 1, 0, "low_0959");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0958, 1, 0, "dec_0958");

        // 6: async reset mid-RUN with clk_one_sec held high
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 16'h0300, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        push_exp("reset_held", 16'h0300, 1'b0, 1'b0);
        check_pop();
        rst_n = 1'b1;
        cyc(0, 16'h0000, 1, 0, 1, 16'h0300, 1, 0, "start_while_high");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0300, 1, 0, "still_high_no_dec");
        cyc(0, 16'h0000, 0, 0, 0, 16'h0300, 1, 0, "low_0300");
        cyc(0, 16'h0000, 0, 0, 1, 16'h0259, 1, 0, "first_edge_0259");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Consumes the divided `clk_one_sec` level from the clock divisor, one stage downstream.
- Runs a loadable MM:SS countdown game timer held as four BCD digits.
- Digits feed the seven-segment display driver; `time_up` feeds game control.
- Runs entirely in the `clk` domain. `clk_one_sec` is treated as a level whose rising edge is detected internally; it is never used as a clock.

Parameters:
- INIT_MIN, 8'h03, BCD minutes loaded at reset.
- INIT_SEC, 8'h00, BCD seconds loaded at reset; must be ≤ 8'h59.

Ports:
- clk  in  1  system clock, same clock that drives the divisor
- rst_n  in  1  asynchronous active-low reset
- clk_one_sec  in  1  1 Hz, 50% duty level from the divisor, synchronous to clk
- load  in  1  load preset; honoured only when not running
- preset  in  16  BCD MM:SS as {min_tens, min_ones, sec_tens, sec_ones}
- start  in  1  start or resume countdown
- pause  in  1  pause countdown
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current BCD digits
- running  out  1  high while in RUN
- time_up  out  1  one-cycle pulse when the count reaches 00:00

Behaviour:
- Single clock edge. Every output is registered.
- Reset (async, rst_n=0) sets:
  - state=IDLE
  - digits=INIT_MIN:INIT_SEC
  - prev_sec=0
  - running=0, time_up=0
- Tick detection:
  - prev_sec <= clk_one_sec every cycle, in every state.
  - tick = clk_one_sec & ~prev_sec (combinational).
  - Digits change at the same edge that samples tick=1, i.e. they are visible the cycle after clk_one_sec is first seen high.
- The divisor phase is not realigned on start. The first second after start or resume is partial, by design.
- States:
  - IDLE:
    - load: sanitised preset is written to the digits; stay IDLE.
    - start with count≠0: go to RUN.
    - start with count==0: go to DONE and pulse time_up.
  - RUN:
    - pause: go to PAUSE. pause wins over start and over a same-cycle tick; no decrement that cycle.
    - otherwise on tick: decrement by one second.
    - If the decremented value is 00:00, go to DONE with time_up=1 at that same edge.
    - load is ignored.
  - PAUSE:
    - Ticks are ignored.
    - start: same rules as IDLE.
    - load: load the digits and go to IDLE.
    - pause is ignored.
  - DONE:
    - Holds 00:00; ticks, start and pause are ignored.
    - load: load the digits and go to IDLE.
- load and start in the same cycle (IDLE/PAUSE/DONE): load wins; start is ignored.
- Decrement arithmetic uses a BCD borrow chain:
  - sec_ones 0→9 with borrow.
  - sec_tens 0→5 with borrow.
  - min_ones 0→9 with borrow.
  - min_tens decrements.
  - 00:00 is never decremented, so there is no wrap to 99:59.
- Sanitising on load:
  - Any digit >9 becomes 9.
  - sec_tens >5 becomes 5.
  - Example: 16'h7A6F loads as 79:59.
- time_up:
  - Exactly one cycle high per entry to DONE.
  - Cleared the next cycle.
  - Never asserted in any other state.
- running = (state==RUN), registered alongside the state.
- Reset mid-operation: immediate return to the reset values.
  - Because prev_sec=0 after reset, a held-high clk_one_sec produces a tick. That tick is harmless because the state is IDLE.

Decomposition:
- Shared package `timer_pkg`:
  - state encoding TMR_IDLE/RUN/PAUSE/DONE (2 bits)
  - BCD digit width 4
  - SEC_TENS_MAX=5, DIGIT_MAX=9
- One sub-module `bcd_down_digit`: combinational.
  - Inputs: digit, max, borrow_in.
  - Outputs: digit_next, borrow_out.
  - Instantiated four times to form the borrow chain.
- The FSM, edge detector and load sanitiser stay in `countdown_timer`.

Test Plan:
1. Reset release → digits 0,3,0,0; running=0; time_up=0. Pulse clk_one_sec → no change.
2. Load 16'h0102, start, drive 3 clk_one_sec rising edges → 01:01, then 01:00, then 00:59; each changes one cycle after the edge.
3. Load 16'h0002, start, 2 edges → 00:01, then 00:00 with time_up high exactly one cycle and running=0. Further edges → stays 00:00; start is ignored.
4. In RUN, assert pause with a tick in the same cycle → no decrement, PAUSE. Two edges → unchanged. Start → RUN, next edge decrements. start+pause together in RUN → PAUSE.
5. Load 16'h7A6F in IDLE → 79:59. In RUN, load 16'h0000 → ignored, count continues. Load+start together in PAUSE → loaded, IDLE.
6. Assert rst_n low mid-RUN with clk_one_sec high → digits 03:00 and running=0 asynchronously. Release, start while clk_one_sec is still high → no decrement until the next low→high edge.
